data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/arb_pkg.sv | 19 +
 rtl/arb_rr_pick.sv | 35 +++
 rtl/data_mem_arbiter.sv | 120 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// read-owner identifiers and a helper for sizing the burst counter.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_e;

   localparam logic OWNER_CPU = 1'b0;
   localparam logic OWNER_LD  = 1'b1;

   // Bits needed to hold the values 0..maxVal inclusive.
   function automatic int unsigned cntWidth(input int unsigned maxVal);
      return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
   endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational grant selector for the two data-memory requesters.
// A lone requester always wins; on contention the loader keeps the port
// while its burst lock is open, otherwise ownership alternates.
module arb_rr_pick
   import arb_pkg::*;
(
   input  arb_state_e state_i,
   input  logic       m0Req_i,
   input  logic       m1Req_i,
   input  logic       m1Lock_i,
   input  logic       burstOpen_i,
   output logic       gnt0_o,
   output logic       gnt1_o
);

   // Pick at most one winner from the last owner and the live requests.
   always_comb begin
      gnt0_o = 1'b0;
      gnt1_o = 1'b0;
      if (m0Req_i && !m1Req_i) begin
         gnt0_o = 1'b1;
      end else if (!m0Req_i && m1Req_i) begin
         gnt1_o = 1'b1;
      end else if (m0Req_i && m1Req_i) begin
         if ((state_i == OWN1) && m1Lock_i && burstOpen_i) begin
            gnt1_o = 1'b1;
         end else if (state_i == OWN0) begin
            gnt1_o = 1'b1;
         end else begin
            gnt0_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data RAM.
// Port 0 is the CPU MEM stage, port 1 the loader/DMA engine. Grants are
// issued in the request cycle, read data returns one cycle later to the
// requester that issued the read.
module data_mem_arbiter
   import arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9,
   parameter int BURST_MAX  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic                  m1_lock,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic                  m0_gnt,
   output logic                  m1_gnt,
   output logic                  m0_rvalid,
   output logic                  m1_rvalid,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  cpu_stall,
   output logic                  ram_we,
   output logic                  ram_re,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata
);

   localparam int                CNT_W       = int'(cntWidth(BURST_MAX));
   localparam logic [CNT_W-1:0]  BURST_LIMIT = CNT_W'(BURST_MAX);

   arb_state_e       state_q, state_d;
   logic [CNT_W-1:0] burstCnt_q, burstCnt_d;
   logic             rdValid_q, rdValid_d;
   logic             rdOwner_q, rdOwner_d;
   logic             pickGnt0, pickGnt1;
   logic             burstOpen;

   assign burstOpen = (burstCnt_q < BURST_LIMIT);

   arb_rr_pick u_pick (
      .state_i     (state_q),
      .m0Req_i     (m0_req),
      .m1Req_i     (m1_req),
      .m1Lock_i    (m1_lock),
      .burstOpen_i (burstOpen),
      .gnt0_o      (pickGnt0),
      .gnt1_o      (pickGnt1)
   );

   // Grants are suppressed while reset is held so nothing reaches the RAM.
   assign m0_gnt    = rst_n & pickGnt0;
   assign m1_gnt    = rst_n & pickGnt1;
   assign cpu_stall = m0_req & ~m0_gnt;

   // Route the winner's address, data and strobe to the RAM; idle bus is zero.
   always_comb begin
      ram_addr  = '0;
      ram_wdata = '0;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      if (m0_gnt) begin
         ram_addr  = m0_addr;
         ram_wdata = m0_wdata;
         ram_we    = m0_we;
         ram_re    = ~m0_we;
      end else if (m1_gnt) begin
         ram_addr  = m1_addr;
         ram_wdata = m1_wdata;
         ram_we    = m1_we;
         ram_re    = ~m1_we;
      end
   end

   // Next owner state, burst length and pending-read bookkeeping.
   always_comb begin
      state_d    = IDLE;
      burstCnt_d = '0;
      rdValid_d  = ram_re;
      rdOwner_d  = rdOwner_q;
      if (m0_gnt) begin
         state_d = OWN0;
      end else if (m1_gnt) begin
         state_d = OWN1;
      end
      if (m1_gnt && m1_lock) begin
         burstCnt_d = (burstCnt_q == BURST_LIMIT) ? burstCnt_q : burstCnt_q + CNT_W'(1);
      end
      if (ram_re) begin
         rdOwner_d = m1_gnt ? OWNER_LD : OWNER_CPU;
      end
   end

   // State registers; reset drops any read still in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         burstCnt_q <= '0;
         rdValid_q  <= 1'b0;
         rdOwner_q  <= OWNER_CPU;
      end else begin
         state_q    <= state_d;
         burstCnt_q <= burstCnt_d;
         rdValid_q  <= rdValid_d;
         rdOwner_q  <= rdOwner_d;
      end
   end

   assign m0_rvalid = rdValid_q & (rdOwner_q == OWNER_CPU);
   assign m1_rvalid = rdValid_q & (rdOwner_q == OWNER_LD);
   assign rdata     = (m0_rvalid | m1_rvalid) ? ram_rdata : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter: a table of directed vectors, hand-written
// lock-burst and reset sequences, then randomized traffic, all compared
// against a request-level reference model and a behavioural RAM.
module tb_data_mem_arbiter;

   localparam int DW = 32;
   localparam int AW = 9;
   localparam int BM = 8;

   logic          clk;
   logic          rst_n;
   logic          m0_req, m0_we;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata;
   logic          m1_req, m1_we, m1_lock;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata;
   logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, cpu_stall;
   logic [DW-1:0] rdata;
   logic          ram_we, ram_re;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;

   int testsRun    = 0;
   int testsFailed = 0;

   typedef struct {
      logic          m0Req;
      logic          m0We;
      logic [AW-1:0] m0Addr;
      logic [DW-1:0] m0Wdata;
      logic          m1Req;
      logic          m1We;
      logic          m1Lock;
      logic [AW-1:0] m1Addr;
      logic [DW-1:0] m1Wdata;
      bit            hasExp;
      logic          expGnt0;
      logic          expGnt1;
      logic          expStall;
      bit            hasData;
      logic          expRe;
      logic          expWe;
      logic [AW-1:0] expAddr;
      logic [DW-1:0] expWdata;
      logic          expRv0;
      logic          expRv1;
      logic [DW-1:0] expRdata;
   } vec_t;

   vec_t tbl [16];

   data_mem_arbiter #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .BURST_MAX  (BM)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .m0_req    (m0_req),
      .m0_we     (m0_we),
      .m0_addr   (m0_addr),
      .m0_wdata  (m0_wdata),
      .m1_req    (m1_req),
      .m1_we     (m1_we),
      .m1_lock   (m1_lock),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m0_gnt    (m0_gnt),
      .m1_gnt    (m1_gnt),
      .m0_rvalid (m0_rvalid),
      .m1_rvalid (m1_rvalid),
      .rdata     (rdata),
      .cpu_stall (cpu_stall),
      .ram_we    (ram_we),
      .ram_re    (ram_re),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Power-on contents of the RAM: a fixed word at 0x010, elsewhere an address pattern.
   function automatic logic [DW-1:0] ramInit(input logic [AW-1:0] a);
      if (a == 9'h010) return 32'hDEADBEEF;
      return 32'h5A000000 | (32'(a) << 12) | 32'(a);
   endfunction

   // Behavioural synchronous RAM; unread cycles return junk to expose missing masking.
   logic [DW-1:0] mem     [512];
   bit            written [512];
   always @(posedge clk) begin
      if (ram_we) begin
         mem[ram_addr]     <= ram_wdata;
         written[ram_addr] <= 1'b1;
      end
      if (ram_re) ram_rdata <= written[ram_addr] ? mem[ram_addr] : ramInit(ram_addr);
      else        ram_rdata <= $urandom;
   end

   // Reference model: who owned the port last, current locked streak, pending read.
   int            mLast   = 0;
   int            mStreak = 0;
   int            mPend   = -1;
   logic [DW-1:0] mPendData;
   logic [DW-1:0] modelMem     [512];
   bit            modelWritten [512];

   function automatic logic [DW-1:0] modelRead(input logic [AW-1:0] a);
      return modelWritten[a] ? modelMem[a] : ramInit(a);
   endfunction

   // 0 = nobody, 1 = CPU, 2 = loader.
   function automatic int modelPick(input logic r0, input logic r1, input logic lk);
      if (!r0 && !r1) return 0;
      if (r0 && !r1)  return 1;
      if (!r0 && r1)  return 2;
      if (mLast == 2 && lk && mStreak < BM) return 2;
      return (mLast == 1) ? 2 : 1;
   endfunction

   function automatic vec_t mk(input int r0, input int w0, input int a0, input logic [DW-1:0] d0,
                               input int r1, input int w1, input int lk, input int a1, input logic [DW-1:0] d1);
      vec_t v;
      v = '{default: '0};
      v.m0Req = (r0 != 0); v.m0We = (w0 != 0); v.m0Addr = AW'(a0); v.m0Wdata = d0;
      v.m1Req = (r1 != 0); v.m1We = (w1 != 0); v.m1Lock = (lk != 0); v.m1Addr = AW'(a1); v.m1Wdata = d1;
      return v;
   endfunction

   function automatic vec_t ex(input vec_t vi, input int g0, input int g1, input int st);
      vec_t v;
      v = vi;
      v.hasExp = 1'b1; v.expGnt0 = (g0 != 0); v.expGnt1 = (g1 != 0); v.expStall = (st != 0);
      return v;
   endfunction

   function automatic vec_t exd(input vec_t vi, input int re, input int we, input int a, input logic [DW-1:0] wd,
                                input int rv0, input int rv1, input logic [DW-1:0] rd);
      vec_t v;
      v = vi;
      v.hasData = 1'b1; v.expRe = (re != 0); v.expWe = (we != 0); v.expAddr = AW'(a); v.expWdata = wd;
      v.expRv0 = (rv0 != 0); v.expRv1 = (rv1 != 0); v.expRdata = rd;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h at time %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive v, check outputs mid-cycle, then advance the model.
   task automatic applyStimulus(input vec_t v);
      int            win;
      logic [AW-1:0] eAddr;
      logic [DW-1:0] eWdata;
      logic          eWe, eRe, eRv0, eRv1;
      logic [DW-1:0] eRdata;
      m0_req = v.m0Req; m0_we = v.m0We; m0_addr = v.m0Addr; m0_wdata = v.m0Wdata;
      m1_req = v.m1Req; m1_we = v.m1We; m1_lock = v.m1Lock; m1_addr = v.m1Addr; m1_wdata = v.m1Wdata;
      win    = rst_n ? modelPick(v.m0Req, v.m1Req, v.m1Lock) : 0;
      eAddr  = (win == 1) ? v.m0Addr  : (win == 2) ? v.m1Addr  : '0;
      eWdata = (win == 1) ? v.m0Wdata : (win == 2) ? v.m1Wdata : '0;
      eWe    = (win == 1) ? v.m0We    : (win == 2) ? v.m1We    : 1'b0;
      eRe    = (win != 0) && !eWe;
      eRv0   = rst_n && (mPend == 0);
      eRv1   = rst_n && (mPend == 1);
      eRdata = (eRv0 || eRv1) ? mPendData : '0;
      @(negedge clk);
      checkOutput("m0_gnt",    32'(m0_gnt),    32'(win == 1));
      checkOutput("m1_gnt",    32'(m1_gnt),    32'(win == 2));
      checkOutput("cpu_stall", 32'(cpu_stall), 32'(v.m0Req && win != 1));
      checkOutput("ram_we",    32'(ram_we),    32'(eWe));
      checkOutput("ram_re",    32'(ram_re),    32'(eRe));
      checkOutput("ram_addr",  32'(ram_addr),  32'(eAddr));
      checkOutput("ram_wdata", ram_wdata,      eWdata);
      checkOutput("m0_rvalid", 32'(m0_rvalid), 32'(eRv0));
      checkOutput("m1_rvalid", 32'(m1_rvalid), 32'(eRv1));
      checkOutput("rdata",     rdata,          eRdata);
      if (v.hasExp) begin
         checkOutput("dir_m0_gnt",    32'(m0_gnt),    32'(v.expGnt0));
         checkOutput("dir_m1_gnt",    32'(m1_gnt),    32'(v.expGnt1));
         checkOutput("dir_cpu_stall", 32'(cpu_stall), 32'(v.expStall));
      end
      if (v.hasData) begin
         checkOutput("dir_ram_re",    32'(ram_re),    32'(v.expRe));
         checkOutput("dir_ram_we",    32'(ram_we),    32'(v.expWe));
         checkOutput("dir_ram_addr",  32'(ram_addr),  32'(v.expAddr));
         checkOutput("dir_ram_wdata", ram_wdata,      v.expWdata);
         checkOutput("dir_m0_rvalid", 32'(m0_rvalid), 32'(v.expRv0));
         checkOutput("dir_m1_rvalid", 32'(m1_rvalid), 32'(v.expRv1));
         checkOutput("dir_rdata",     rdata,          v.expRdata);
      end
      @(posedge clk);
      if (!rst_n) begin
         mLast = 0; mStreak = 0; mPend = -1;
      end else begin
         mPend = -1;
         if (win != 0) begin
            if (eWe) begin
               modelMem[eAddr]     = eWdata;
               modelWritten[eAddr] = 1'b1;
            end else begin
               mPend     = win - 1;
               mPendData = modelRead(eAddr);
            end
         end
         if (win == 2 && v.m1Lock) mStreak = (mStreak < BM) ? mStreak + 1 : BM;
         else                      mStreak = 0;
         mLast = win;
      end
      #1;
   endtask

   initial begin
      vec_t v;
      rst_n = 1'b0;
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
      m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = '0; m1_wdata = '0;

      // Directed vectors, applied back to back starting from the reset state.
      tbl[0]  = exd(ex(mk(1,0,'h010,0, 0,0,0,0,0), 1,0,0), 1,0,'h010,0, 0,0,0);
      tbl[1]  = exd(ex(mk(0,0,0,0, 0,0,0,0,0), 0,0,0), 0,0,0,0, 1,0,32'hDEADBEEF);
      tbl[2]  = exd(ex(mk(1,0,'h020,0, 1,0,0,'h030,0), 1,0,0), 1,0,'h020,0, 0,0,0);
      tbl[3]  = exd(ex(mk(1,0,'h020,0, 1,0,0,'h030,0), 0,1,1), 1,0,'h030,0, 1,0,32'h5A020020);
      tbl[4]  = exd(ex(mk(1,0,'h020,0, 1,0,0,'h030,0), 1,0,0), 1,0,'h020,0, 0,1,32'h5A030030);
      tbl[5]  = exd(ex(mk(1,0,'h020,0, 1,0,0,'h030,0), 0,1,1), 1,0,'h030,0, 1,0,32'h5A020020);
      tbl[6]  = exd(ex(mk(0,0,0,0, 1,1,0,'h1FF,32'h12345678), 0,1,0), 0,1,'h1FF,32'h12345678, 0,1,32'h5A030030);
      tbl[7]  = exd(ex(mk(0,0,0,0, 0,0,0,0,0), 0,0,0), 0,0,0,0, 0,0,0);
      tbl[8]  = exd(ex(mk(1,0,'h004,0, 0,0,0,0,0), 1,0,0), 1,0,'h004,0, 0,0,0);
      tbl[9]  = exd(ex(mk(0,0,0,0, 1,0,0,'h008,0), 0,1,0), 1,0,'h008,0, 1,0,32'h5A004004);
      tbl[10] = exd(ex(mk(0,0,0,0, 0,0,0,0,0), 0,0,0), 0,0,0,0, 0,1,32'h5A008008);
      tbl[11] = exd(ex(mk(0,0,0,0, 1,0,0,'h1FF,0), 0,1,0), 1,0,'h1FF,0, 0,0,0);
      tbl[12] = exd(ex(mk(0,0,0,0, 0,0,0,0,0), 0,0,0), 0,0,0,0, 0,1,32'h12345678);
      tbl[13] = exd(ex(mk(1,1,'h055,32'hCAFEF00D, 0,0,0,0,0), 1,0,0), 0,1,'h055,32'hCAFEF00D, 0,0,0);
      tbl[14] = exd(ex(mk(1,0,'h055,0, 0,0,0,0,0), 1,0,0), 1,0,'h055,0, 0,0,0);
      tbl[15] = exd(ex(mk(0,0,0,0, 0,0,0,0,0), 0,0,0), 0,0,0,0, 1,0,32'hCAFEF00D);

      // Held in reset with both requesting: no grants, no strobes, CPU stalls.
      for (int i = 0; i < 2; i++) begin
         applyStimulus(exd(ex(mk(1,0,'h010,0, 1,1,1,'h020,32'h1), 0,0,1), 0,0,0,0, 0,0,0));
      end
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) applyStimulus(tbl[i]);

      // Locked loader burst from IDLE: m0, eight m1 grants, one m0, then m1 again.
      for (int i = 0; i < 12; i++) begin
         v = mk(1,0,'h011,0, 1,0,1,'h012,0);
         if (i == 0 || i == 9) applyStimulus(ex(v, 1,0,0));
         else                  applyStimulus(ex(v, 0,1,1));
      end

      // Reset lands the cycle after a loader read grant; the return must vanish.
      applyStimulus(ex(mk(0,0,0,0, 1,0,0,'h030,0), 0,1,0));
      rst_n = 1'b0;
      applyStimulus(exd(ex(mk(1,0,'h004,0, 1,0,0,'h008,0), 0,0,1), 0,0,0,0, 0,0,0));
      rst_n = 1'b1;
      applyStimulus(exd(ex(mk(0,0,0,0, 0,0,0,0,0), 0,0,0), 0,0,0,0, 0,0,0));
      applyStimulus(ex(mk(1,0,'h004,0, 1,0,0,'h008,0), 1,0,0));
      applyStimulus(exd(ex(mk(0,0,0,0, 0,0,0,0,0), 0,0,0), 0,0,0,0, 1,0,32'h5A004004));

      // Randomized traffic with occasional resets, checked against the model only.
      for (int i = 0; i < 600; i++) begin
         rst_n = ($urandom_range(0, 49) != 0);
         v = mk(($urandom_range(0, 9) < 7) ? 1 : 0, ($urandom_range(0, 9) < 3) ? 1 : 0,
                int'($urandom_range(0, 511)), $urandom,
                ($urandom_range(0, 9) < 7) ? 1 : 0, ($urandom_range(0, 9) < 3) ? 1 : 0,
                ($urandom_range(0, 9) < 6) ? 1 : 0, int'($urandom_range(0, 511)), $urandom);
         applyStimulus(v);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
